// File: rtl/rp_pkg.sv
// RP06 geometry, command encodings and request FSM states for the SD request path.
// Pure declarations: no latency, no flow control.
package rp_pkg;
  localparam int unsigned RP06_NSECT = 20;
  localparam int unsigned RP06_NTRK  = 19;
  localparam int unsigned RP06_NCYL  = 815;
  localparam int unsigned LBA_W      = 24;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_WRCHK = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_REQ, S_START, S_WAIT, S_NEXT, S_DONE
  } rq_state_t;

  // The reserved opcode is executed as a plain read.
  function automatic logic [1:0] norm_op(input logic [1:0] op);
    return (op == OP_RSVD) ? OP_READ : op;
  endfunction
endpackage

// File: rtl/rp_lba.sv
// Cylinder/track/sector to linear block address converter.
// One cycle from load to lba; holds its value while load is low.
module rp_lba
  import rp_pkg::*;
#(
  parameter int unsigned NSECT = RP06_NSECT,
  parameter int unsigned NTRK  = RP06_NTRK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [9:0]       cyl,
  input  logic [5:0]       trk,
  input  logic [5:0]       sec,
  output logic [LBA_W-1:0] lba
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lba <= '0;
    else if (load)
      lba <= (LBA_W'(cyl) * LBA_W'(NTRK) + LBA_W'(trk)) * LBA_W'(NSECT) + LBA_W'(sec);
  end
endmodule

// File: rtl/rp_sd_request.sv
// Walks a multi-sector RP transfer, issuing one SD operation per sector via the shared SD scanner.
// sdREQ two cycles after go; sdSTART waits for sdACK and the whole walk stalls while the grant is withdrawn.
module rp_sd_request
  import rp_pkg::*;
#(
  parameter int unsigned NSECT = RP06_NSECT,
  parameter int unsigned NTRK  = RP06_NTRK,
  parameter int unsigned NCYL  = RP06_NCYL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             go,
  input  logic [1:0]       op,
  input  logic [9:0]       cylIn,
  input  logic [5:0]       trkIn,
  input  logic [5:0]       secIn,
  input  logic [7:0]       nsec,
  output logic             sdREQ,
  input  logic             sdACK,
  output logic             sdSTART,
  output logic [1:0]       sdOP,
  output logic [LBA_W-1:0] sdLBA,
  input  logic             sdDONE,
  input  logic             sdERR,
  output logic [9:0]       cyl,
  output logic [5:0]       trk,
  output logic [5:0]       sec,
  output logic             busy,
  output logic             cmdDONE,
  output logic             aoe,
  output logic             sdfail
);
  rq_state_t  state;
  logic [8:0] count;
  logic       start_q;
  logic       hold;
  logic       addr_ok;
  logic       lba_ld;

  assign hold    = sdREQ & ~sdACK;
  assign addr_ok = (32'(cyl) < NCYL) && (32'(trk) < NTRK) && (32'(sec) < NSECT);
  assign lba_ld  = (state == S_CALC) && addr_ok && !hold;
  // The strobe is only ever visible together with the grant.
  assign sdSTART = start_q & sdACK;

  rp_lba #(.NSECT(NSECT), .NTRK(NTRK)) u_lba (
    .clk  (clk),
    .rst  (rst),
    .load (lba_ld),
    .cyl  (cyl),
    .trk  (trk),
    .sec  (sec),
    .lba  (sdLBA)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      sdREQ   <= 1'b0;
      start_q <= 1'b0;
      busy    <= 1'b0;
      cmdDONE <= 1'b0;
      aoe     <= 1'b0;
      sdfail  <= 1'b0;
      sdOP    <= OP_READ;
      cyl     <= '0;
      trk     <= '0;
      sec     <= '0;
      count   <= '0;
    end else if (clr) begin
      state   <= S_IDLE;
      sdREQ   <= 1'b0;
      start_q <= 1'b0;
      busy    <= 1'b0;
      cmdDONE <= 1'b0;
      aoe     <= 1'b0;
      sdfail  <= 1'b0;
    end else begin
      cmdDONE <= 1'b0;
      case (state)
        S_IDLE: if (go) begin
          sdOP   <= norm_op(op);
          cyl    <= cylIn;
          trk    <= trkIn;
          sec    <= secIn;
          count  <= (nsec == 8'd0) ? 9'd256 : {1'b0, nsec};
          aoe    <= 1'b0;
          sdfail <= 1'b0;
          busy   <= 1'b1;
          state  <= S_CALC;
        end
        S_CALC: if (!hold) begin
          if (!addr_ok) begin
            aoe     <= 1'b1;
            sdREQ   <= 1'b0;
            cmdDONE <= 1'b1;
            state   <= S_DONE;
          end else begin
            sdREQ <= 1'b1;
            state <= S_REQ;
          end
        end
        S_REQ: if (sdACK) begin
          start_q <= 1'b1;
          state   <= S_START;
        end
        S_START: if (sdACK) begin
          start_q <= 1'b0;
          state   <= S_WAIT;
        end
        S_WAIT: if (sdACK && sdDONE) begin
          if (sdERR) begin
            sdfail  <= 1'b1;
            sdREQ   <= 1'b0;
            cmdDONE <= 1'b1;
            state   <= S_DONE;
          end else if (count == 9'd1) begin
            count   <= '0;
            sdREQ   <= 1'b0;
            cmdDONE <= 1'b1;
            state   <= S_DONE;
          end else begin
            count <= count - 9'd1;
            state <= S_NEXT;
          end
        end
        // sdREQ stays up across NEXT/CALC so the scanner keeps this drive's grant.
        S_NEXT: if (!hold) begin
          if (32'(sec) != NSECT - 1) begin
            sec   <= sec + 6'd1;
            state <= S_CALC;
          end else if (32'(trk) != NTRK - 1) begin
            sec   <= '0;
            trk   <= trk + 6'd1;
            state <= S_CALC;
          end else if (32'(cyl) + 32'd1 >= NCYL) begin
            aoe     <= 1'b1;
            sdREQ   <= 1'b0;
            cmdDONE <= 1'b1;
            state   <= S_DONE;
          end else begin
            sec   <= '0;
            trk   <= '0;
            cyl   <= cyl + 10'd1;
            state <= S_CALC;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rp_sd_request.sv
// Directed and randomized commands against a linear-address reference model of the RP06 SD request walker.
module tb_rp_sd_request;
  localparam int G_S = 20;
  localparam int G_T = 19;
  localparam int G_C = 815;

  logic        clk = 1'b0;
  logic        rst, clr, go;
  logic [1:0]  op;
  logic [9:0]  cylIn;
  logic [5:0]  trkIn, secIn;
  logic [7:0]  nsec;
  logic        sdREQ, sdACK, sdSTART;
  logic [1:0]  sdOP;
  logic [23:0] sdLBA;
  logic        sdDONE, sdERR;
  logic [9:0]  cyl;
  logic [5:0]  trk, sec;
  logic        busy, cmdDONE, aoe, sdfail;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rp_sd_request dut (
    .clk(clk), .rst(rst), .clr(clr), .go(go), .op(op),
    .cylIn(cylIn), .trkIn(trkIn), .secIn(secIn), .nsec(nsec),
    .sdREQ(sdREQ), .sdACK(sdACK), .sdSTART(sdSTART), .sdOP(sdOP), .sdLBA(sdLBA),
    .sdDONE(sdDONE), .sdERR(sdERR), .cyl(cyl), .trk(trk), .sec(sec),
    .busy(busy), .cmdDONE(cmdDONE), .aoe(aoe), .sdfail(sdfail)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One command: model it, play the SD scanner/controller, then compare.
  task automatic run_cmd(input string tag, input int op_i, input int c, input int t, input int s,
                         input int n_i, input int err_idx, input int ack_dly, input int lat,
                         input bit glitch, input bit clr_wait);
    int exp_lba[$];
    int got_lba[$];
    int exp_aoe = 0, exp_fail = 0;
    int fc = c, ft = t, fs = s;
    int lin, n, total, budget, cyc;
    int req_first = -1, start_cyc = -1, last_done = -1, fall_cyc = -1, done_cyc = -1, clr_cyc = -1;
    int nstart = 0, ndone = 0, nrise = 0, bad_start = 0;
    int prev_req = 0, timed_out = 1, req_after_clr = 1, busy_after_clr = 1, op_seen = 0;

    n     = (n_i == 0) ? 256 : n_i;
    total = G_C * G_T * G_S;
    if (c >= G_C || t >= G_T || s >= G_S) begin
      exp_aoe = 1;
    end else begin
      lin = (c * G_T + t) * G_S + s;
      for (int i = 0; i < n; i++) begin
        exp_lba.push_back(lin);
        if (i == err_idx) begin exp_fail = 1; break; end
        if (i == n - 1) break;
        if (lin + 1 == total) begin exp_aoe = 1; break; end
        lin++;
      end
      fs = lin % G_S;
      ft = (lin / G_S) % G_T;
      fc = lin / (G_S * G_T);
    end
    budget = 40 + n * (lat + ack_dly + 12);

    @(posedge clk); #1;
    go = 1'b1; op = 2'(op_i); cylIn = 10'(c); trkIn = 6'(t); secIn = 6'(s); nsec = 8'(n_i);
    for (cyc = 0; cyc < budget; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        go = glitch && start_cyc >= 0 && cyc == start_cyc + 1;
        if (go) begin cylIn = 10'd1; trkIn = 6'd0; secIn = 6'd0; nsec = 8'd9; op = 2'd1; end
        sdACK = prev_req != 0 && req_first >= 0 && cyc >= req_first + ack_dly &&
                !(glitch && start_cyc >= 0 && (cyc == start_cyc + 1 || cyc == start_cyc + 2));
        sdDONE = (start_cyc >= 0 && cyc == start_cyc + lat) ||
                 (glitch && start_cyc >= 0 && cyc == start_cyc + 1);
        sdERR  = sdDONE && (nstart - 1 == err_idx || (glitch && cyc == start_cyc + 1));
        clr    = clr_wait && start_cyc >= 0 && cyc == start_cyc + 2;
        if (clr) clr_cyc = cyc;
      end
      @(negedge clk);
      if (sdSTART) begin
        nstart++;
        got_lba.push_back(int'(sdLBA));
        op_seen   = int'(sdOP);
        start_cyc = cyc;
        if (!sdACK) bad_start++;
      end
      if (sdDONE && sdACK) last_done = cyc;
      if (sdREQ && prev_req == 0) begin nrise++; if (req_first < 0) req_first = cyc; end
      if (!sdREQ && prev_req != 0) fall_cyc = cyc;
      if (cmdDONE) begin ndone++; done_cyc = cyc; end
      prev_req = int'(sdREQ);
      if (clr_cyc >= 0 && cyc == clr_cyc + 1) begin
        req_after_clr  = int'(sdREQ);
        busy_after_clr = int'(busy);
      end
      if ((ndone > 0 && cyc >= done_cyc + 2) || (clr_cyc >= 0 && cyc >= clr_cyc + 4)) begin
        timed_out = 0;
        break;
      end
    end
    go = 1'b0; sdACK = 1'b0; sdDONE = 1'b0; sdERR = 1'b0; clr = 1'b0;

    chk({tag, ".terminated"}, timed_out, 0);
    chk({tag, ".start_without_ack"}, bad_start, 0);
    if (clr_wait) begin
      chk({tag, ".sdreq_after_clr"}, req_after_clr, 0);
      chk({tag, ".busy_after_clr"}, busy_after_clr, 0);
      chk({tag, ".cmddone_count"}, ndone, 0);
      chk({tag, ".starts"}, nstart, 1);
      chk({tag, ".aoe"}, 32'(aoe), 0);
      chk({tag, ".sdfail"}, 32'(sdfail), 0);
    end else begin
      chk({tag, ".cmddone_count"}, ndone, 1);
      chk({tag, ".starts"}, nstart, exp_lba.size());
      for (int i = 0; i < exp_lba.size() && i < got_lba.size(); i++)
        chk($sformatf("%s.lba%0d", tag, i), got_lba[i], exp_lba[i]);
      chk({tag, ".aoe"}, 32'(aoe), exp_aoe);
      chk({tag, ".sdfail"}, 32'(sdfail), exp_fail);
      chk({tag, ".cyl"}, 32'(cyl), fc);
      chk({tag, ".trk"}, 32'(trk), ft);
      chk({tag, ".sec"}, 32'(sec), fs);
      chk({tag, ".busy_end"}, 32'(busy), 0);
      chk({tag, ".sdreq_rises"}, nrise, (exp_lba.size() > 0) ? 1 : 0);
      if (exp_lba.size() > 0) begin
        chk({tag, ".sdreq_fall_after_done"}, fall_cyc - last_done, (exp_aoe != 0) ? 2 : 1);
        chk({tag, ".sdop"}, op_seen, (op_i == 3) ? 0 : op_i);
      end else begin
        chk({tag, ".cmddone_cycle"}, done_cyc, 2);
      end
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; go = 1'b0; op = 2'd0; cylIn = '0; trkIn = '0; secIn = '0;
    nsec = '0; sdACK = 1'b0; sdDONE = 1'b0; sdERR = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.sdreq", 32'(sdREQ), 0);
    chk("reset.sdstart", 32'(sdSTART), 0);
    chk("reset.busy", 32'(busy), 0);
    chk("reset.cmddone", 32'(cmdDONE), 0);
    chk("reset.aoe_sdfail", {30'd0, aoe, sdfail}, 0);
    chk("reset.sdop", 32'(sdOP), 0);
    chk("reset.sdlba", 32'(sdLBA), 0);
    chk("reset.addr", {10'd0, cyl, trk, sec}, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_cmd("basic",      0,   0,  0,  0, 1, -1, 2, 3, 1'b0, 1'b0);
    run_cmd("track_wrap", 1,   5, 18, 19, 2, -1, 1, 4, 1'b0, 1'b0);
    run_cmd("cyl_range",  0, 815,  0,  0, 1, -1, 1, 3, 1'b0, 1'b0);
    run_cmd("disk_end",   2, 814, 18, 19, 2, -1, 1, 3, 1'b0, 1'b0);
    run_cmd("sd_error",   1, 100,  3,  7, 3,  0, 1, 3, 1'b0, 1'b0);
    run_cmd("clr_wait",   0,  10,  0,  0, 4, -1, 1, 5, 1'b0, 1'b1);
    run_cmd("after_clr",  3,  10,  0,  0, 2, -1, 1, 3, 1'b0, 1'b0);
    run_cmd("ack_glitch", 1, 200, 10,  5, 3, -1, 2, 5, 1'b1, 1'b0);
    run_cmd("count256",   0,   0,  0,  0, 0, -1, 1, 2, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      int rc, rt, rs, rn, re, sel;
      sel = int'($urandom_range(0, 5));
      rc  = int'($urandom_range(0, 814));
      rt  = int'($urandom_range(0, 18));
      rs  = int'($urandom_range(0, 19));
      if (sel == 0) begin rc = 814; rt = 18; rs = int'($urandom_range(16, 19)); end
      if (sel == 1) rt = int'($urandom_range(19, 63));
      if (sel == 2) rs = int'($urandom_range(20, 63));
      rn = int'($urandom_range(1, 5));
      re = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32'(rn - 1))) : -1;
      run_cmd($sformatf("rnd%0d", k), int'($urandom_range(0, 3)), rc, rt, rs, rn, re,
              int'($urandom_range(1, 3)), int'($urandom_range(4, 7)),
              1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
